md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the forwarded rs/rt operands produced by the EX operand-select 2:1 muxes.
- Holds the architectural HI/LO registers.
- Exposes busy so the hazard unit can stall md-class instructions.

Parameters:
MULT_CYCLES, 5, cycles busy is held after a mult/multu start (>=1)
DIV_CYCLES, 10, cycles busy is held after a div/divu start (>=1)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle strobe: EX holds a valid md instruction this cycle
md_op  input  3  operation code (see package)
A  input  32  forwarded rs value (operand-mux output)
B  input  32  forwarded rt value (operand-mux output)
busy  output  1  multi-cycle operation in flight
hi  output  32  architectural HI, read by mfhi
lo  output  32  architectural LO, read by mflo

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - hi=0, lo=0, busy=0, state=IDLE, counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, BUSY.
- IDLE + start + md_op in {MULT, MULTU}, sampled at edge t:
  - Latch the 64-bit product into internal res_hi/res_lo.
  - Load counter=MULT_CYCLES; go to BUSY.
- IDLE + start + md_op in {DIV, DIVU}, sampled at edge t:
  - Same as above, with the quotient/remainder and counter=DIV_CYCLES.
- BUSY, each edge:
  - counter decrements.
  - At the edge where counter==1: hi<=res_hi, lo<=res_lo, go to IDLE.
  - busy is high exactly N cycles: edges t+1 through t+N.
  - Sampled at edge t+N (i.e. in the cycle after t+N), hi/lo show the new values.
- MTHI / MTLO with start in IDLE:
  - hi<=A / lo<=A at that edge; busy stays 0; latency 1 edge.
- Other md_op values, or start=0: no state change.
- start while BUSY is a protocol violation (the hazard unit stalls it):
  - The design ignores it; the in-flight result is unaffected.
  - The bench flags it.
- mult: signed 32x32->64. multu: unsigned. hi = product[63:32], lo = product[31:0].
- div (signed): lo = quotient, truncated toward zero; hi = remainder, same sign as dividend A.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (B==0), div or divu:
  - Unit goes BUSY for DIV_CYCLES as normal.
  - hi/lo NOT updated at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Must be explicit, not simulator-defined.
- hi/lo are only written at completion or by mthi/mtlo. No partial values are ever visible.
- Operands are captured at start. Later changes on A/B do not affect the in-flight result.
- Reset deasserted mid-operation: unit starts in IDLE, hi/lo=0.

Decomposition:
- Shared package md_defs:
  - md_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - State enum IDLE=0, BUSY=1.
  - Default cycle constants 5/10.
- Single module; no sub-module needed.
- Arithmetic stays combinational into the result registers. The counter only models latency.
- Stall logic (start-while-busy, mfhi/mflo behind busy) lives in the existing hazard unit, not here.

Test Plan:
- Reset: pulse reset=0 mid-cycle -> hi=0, lo=0, busy=0 immediately, without waiting for clk.
- mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 -> lo=3, hi=1.
- Divide by zero after mthi A=0x1234 and mtlo A=0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged. Also 0x80000000 div 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start mult, then change A/B and pulse start again during BUSY -> result matches the first operands; busy falls on schedule.
- mult in flight, reset=0 at cycle 3 -> busy=0 and hi/lo=0 immediately; no late writeback after reset release.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state type and default latencies.
package md_defs;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at start and held; the counter only models latency.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   state_o
);

  // Handshake: start is a one-cycle strobe honoured only while busy=0;
  // a start seen while busy=1 is dropped and never disturbs the held result.

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, sdiv_b, udiv_b;
  logic [31:0] sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

  // Arithmetic: sign-extend to 64 bits and keep everything unsigned so the
  // low 64 bits of the product are the two's-complement signed result.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};

    a_neg  = A[31];
    b_neg  = B[31];
    a_mag  = a_neg ? (~A + 32'd1) : A;
    b_mag  = b_neg ? (~B + 32'd1) : B;
    // Divisor forced to 1 on divide-by-zero so the datapath never goes X;
    // the write-enable drop below keeps HI/LO untouched in that case.
    sdiv_b = (B == 32'd0) ? 32'd1 : b_mag;
    udiv_b = (B == 32'd0) ? 32'd1 : B;
    sq_mag = a_mag / sdiv_b;
    sr_mag = a_mag % sdiv_b;
    s_quo  = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
    s_rem  = a_neg ? (~sr_mag + 32'd1) : sr_mag;
    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      s_quo = 32'h8000_0000;
      s_rem = 32'd0;
    end
    u_quo = A / udiv_b;
    u_rem = A % udiv_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_DIV: begin
              res_hi_d = s_rem;
              res_lo_d = s_quo;
              wr_d     = (B != 32'd0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = BUSY;
            end
            OP_DIVU: begin
              res_hi_d = u_rem;
              res_lo_d = u_quo;
              wr_d     = (B != 32'd0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops,
// compared against an arithmetic reference model of HI/LO and latency.
module tb_md_unit;
  import md_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;
  md_state_e   state_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one accepted op, returns expected busy cycles.
  function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        {m_hi, m_lo} = p;
        return MC;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
        return MC;
      end
      OP_DIV: begin
        if (b != 0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        return DC;
      end
      OP_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        return DC;
      end
      OP_MTHI: begin m_hi = a; return 0; end
      OP_MTLO: begin m_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Driver: issue one op, optionally inject an illegal start while busy,
  // wiggle A/B during the operation, then score latency and HI/LO.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    int lat, n;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    lat = model(op, a, b);
    exp_q.push_back({m_hi, m_lo});
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'($urandom_range(0, 7));
    A = $urandom;
    B = $urandom;
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1;
        md_op = OP_MULT;
        $display("note: start raised while busy (protocol violation), must be ignored");
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      A = $urandom;
      B = $urandom;
    end
    check($sformatf("lat op%0d", op), 64'(n), 64'(lat));
    exp = exp_q.pop_front();
    check($sformatf("hilo op%0d", op), {hi, lo}, exp);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    start = 1'b0;
    md_op = OP_NONE;
    A = '0;
    B = '0;
    m_hi = '0;
    m_lo = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst hilo", {hi, lo}, 64'd0);
    check("rst state", 64'(state_o), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // asynchronous reset mid-cycle after HI/LO have been loaded
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    check("async rst hilo", {hi, lo}, 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // directed cases
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult -2*3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div -7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU,  32'd7, 32'd2, 1'b0);
    check("divu 7/2", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(OP_MTHI,  32'h0000_1234, 32'd0, 1'b0);
    run_op(OP_MTLO,  32'h0000_5678, 32'd0, 1'b0);
    run_op(OP_DIV,   32'h0000_0055, 32'd0, 1'b0);
    check("div by 0", {hi, lo}, 64'h0000_1234_0000_5678);
    run_op(OP_DIVU,  32'h0000_0077, 32'd0, 1'b0);
    check("divu by 0", {hi, lo}, 64'h0000_1234_0000_5678);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(OP_MULT,  32'h0001_0003, 32'hFFFF_0007, 1'b1);
    run_op(OP_DIVU,  32'hFFFF_FFF0, 32'd9, 1'b1);
    run_op(OP_NONE,  32'h1111_1111, 32'd1, 1'b0);
    run_op(3'd7,     32'h2222_2222, 32'd1, 1'b0);

    // reset while a mult is in flight: no late writeback afterwards
    @(negedge clk);
    start = 1'b1;
    md_op = OP_MULT;
    A = 32'd1000;
    B = 32'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1;
    check("inflight rst busy", 64'(busy), 64'd0);
    check("inflight rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 3) @(posedge clk);
    #1;
    check("post rst busy", 64'(busy), 64'd0);
    check("post rst hilo", {hi, lo}, 64'd0);

    // random ops
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
